// File: rtl/ret_stack_if.sv
// =============================================================================
// ret_stack_if: CU/PC-facing bundle of the return-address stack.
// Rev 1.0
// =============================================================================
`default_nettype none

interface ret_stack_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [AW-1:0] pc;
  logic [AW-1:0] lit;
  logic          jmp;
  logic          call;
  logic          ret;
  logic          clr_err;
  logic [AW-1:0] k8;
  logic          load;
  logic [DW-1:0] depth;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;
  logic          conflict;

  // Master drives the decoded strobes; slave is the stack itself.
  modport master (
    output pc, lit, jmp, call, ret, clr_err,
    input  k8, load, depth, full, empty, overflow, underflow, conflict
  );

  modport slave (
    input  pc, lit, jmp, call, ret, clr_err,
    output k8, load, depth, full, empty, overflow, underflow, conflict
  );
endinterface

`default_nettype wire

// File: rtl/ret_stack.sv
// =============================================================================
// ret_stack: hardware return-address stack driving PC redirects for JMP/CALL/RET.
// Rev 1.0
// =============================================================================
`default_nettype none

module ret_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 8
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  ret_stack_if.slave bus
);
  localparam int            DW      = $clog2(DEPTH + 1);
  localparam int            PW      = $clog2(DEPTH);
  localparam logic [DW-1:0] C_DEPTH = DW'(DEPTH);
  localparam logic [DW-1:0] C_ONE   = DW'(1);

  logic [AW-1:0] mem_q [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          conflict_q, conflict_d;

  logic          do_call, do_jmp, do_ret;
  logic          multi;
  logic          is_full, is_empty;
  logic          push_en, pop_en;
  logic [PW-1:0] top_idx, push_idx;
  logic [AW-1:0] top_val, ret_addr;

  // Strobe arbitration: call beats jmp beats ret; losers have no side effects.
  always_comb begin
    do_call = bus.call;
    do_jmp  = bus.jmp & ~bus.call;
    do_ret  = bus.ret & ~bus.call & ~bus.jmp;
    multi   = (bus.call & bus.jmp) | (bus.call & bus.ret) | (bus.jmp & bus.ret);
  end

  always_comb begin
    is_full  = (depth_q == C_DEPTH);
    is_empty = (depth_q == '0);
    top_idx  = PW'(depth_q - C_ONE);
    push_idx = depth_q[PW-1:0];
    top_val  = mem_q[top_idx];
    ret_addr = bus.pc + AW'(1);
    push_en  = do_call & ~is_full;
    pop_en   = do_ret & ~is_empty;
  end

  always_comb begin
    depth_d = depth_q;
    if (push_en) begin
      depth_d = depth_q + C_ONE;
    end else if (pop_en) begin
      depth_d = depth_q - C_ONE;
    end
  end

  // A fresh error at the same edge as clr_err keeps the flag set.
  always_comb begin
    overflow_d  = (overflow_q  & ~bus.clr_err) | (do_call & is_full);
    underflow_d = (underflow_q & ~bus.clr_err) | (do_ret & is_empty);
    conflict_d  = (conflict_q  & ~bus.clr_err) | multi;
  end

  // Redirect is combinational so the PC loads on the sampling edge.
  always_comb begin
    bus.load = 1'b0;
    bus.k8   = '0;
    if (do_call || do_jmp) begin
      bus.load = 1'b1;
      bus.k8   = bus.lit;
    end else if (pop_en) begin
      bus.load = 1'b1;
      bus.k8   = top_val;
    end
  end

  always_comb begin
    bus.depth     = depth_q;
    bus.full      = is_full;
    bus.empty     = is_empty;
    bus.overflow  = overflow_q;
    bus.underflow = underflow_q;
    bus.conflict  = conflict_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      conflict_q  <= conflict_d;
    end
  end

  // Entry storage is never cleared; entries above depth are unreachable.
  always_ff @(posedge clk) begin
    if (rst_n && push_en) begin
      mem_q[push_idx] <= ret_addr;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ret_stack.sv
// =============================================================================
// tb_ret_stack: vector table, directed corner sequences and randomized model check.
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_ret_stack;
  localparam int DEPTH = 8;
  localparam int AW    = 8;

  logic clk;
  logic rst_n;

  ret_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  ret_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of return addresses plus three sticky bits.
  logic [7:0] mq[$];
  bit m_ovf, m_udf, m_cnf;

  typedef struct {
    logic       c, j, r, clr;
    logic [7:0] pc, lit;
    logic       ld;
    logic [7:0] k8;
    logic [3:0] dep;
    logic       ovf, udf, cnf;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_udf = 0; m_cnf = 0;
  endtask

  task automatic model_predict(input logic c, j, r, input logic [7:0] lit,
                               output logic ld, output logic [7:0] k8);
    ld = 0; k8 = 8'h00;
    if (c || j) begin
      ld = 1; k8 = lit;
    end else if (r && mq.size() > 0) begin
      ld = 1; k8 = mq[mq.size()-1];
    end
  endtask

  task automatic model_step(input logic c, j, r, clr, input logic [7:0] pc);
    bit so, su, sc;
    so = c && (mq.size() == DEPTH);
    su = !c && !j && r && (mq.size() == 0);
    sc = (int'(c) + int'(j) + int'(r)) > 1;
    if (c) begin
      if (mq.size() < DEPTH) mq.push_back(8'(pc + 8'd1));
    end else if (!j && r && mq.size() > 0) begin
      void'(mq.pop_back());
    end
    m_ovf = (m_ovf && !clr) || so;
    m_udf = (m_udf && !clr) || su;
    m_cnf = (m_cnf && !clr) || sc;
  endtask

  task automatic check_model_state(input string tag);
    chk({tag, ".depth"},     32'(bus.depth), 32'(mq.size()));
    chk({tag, ".full"},      32'(bus.full),  32'(mq.size() == DEPTH));
    chk({tag, ".empty"},     32'(bus.empty), 32'(mq.size() == 0));
    chk({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(m_udf));
    chk({tag, ".conflict"},  32'(bus.conflict),  32'(m_cnf));
  endtask

  // Entered at posedge+1; returns at the next posedge+1 with the model advanced.
  task automatic cycle(input logic c, j, r, clr, input logic [7:0] p, l,
                       input bit use_model, input string tag,
                       output logic ld_s, output logic [7:0] k8_s);
    logic       eld;
    logic [7:0] ek8;
    bus.call = c; bus.jmp = j; bus.ret = r; bus.clr_err = clr;
    bus.pc = p; bus.lit = l;
    #2;
    ld_s = bus.load; k8_s = bus.k8;
    model_predict(c, j, r, l, eld, ek8);
    if (use_model) begin
      chk({tag, ".load"}, 32'(ld_s), 32'(eld));
      chk({tag, ".k8"},   32'(k8_s), 32'(ek8));
    end
    @(posedge clk);
    #1;
    model_step(c, j, r, clr, p);
    bus.call = 0; bus.jmp = 0; bus.ret = 0; bus.clr_err = 0;
  endtask

  initial begin
    logic       ld;
    logic [7:0] k8;

    rst_n = 1'b0;
    bus.pc = '0; bus.lit = '0;
    bus.jmp = 0; bus.call = 0; bus.ret = 0; bus.clr_err = 0;
    model_reset();
    #8;
    chk("reset.depth", 32'(bus.depth), 0);
    chk("reset.empty", 32'(bus.empty), 1);
    chk("reset.full",  32'(bus.full),  0);
    chk("reset.flags", {29'd0, bus.overflow, bus.underflow, bus.conflict}, 0);
    chk("reset.load",  32'(bus.load),  0);
    chk("reset.k8",    32'(bus.k8),    0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    //            c j r clr  pc     lit    ld k8     dep  ovf udf cnf
    tbl[0]  = '{1,0,0,0, 8'h10, 8'h40, 1, 8'h40, 4'd1, 0,0,0};
    tbl[1]  = '{0,0,1,0, 8'h40, 8'h00, 1, 8'h11, 4'd0, 0,0,0};
    tbl[2]  = '{1,0,0,0, 8'h05, 8'h40, 1, 8'h40, 4'd1, 0,0,0};
    tbl[3]  = '{1,0,0,0, 8'h41, 8'h80, 1, 8'h80, 4'd2, 0,0,0};
    tbl[4]  = '{1,0,0,0, 8'h81, 8'hC0, 1, 8'hC0, 4'd3, 0,0,0};
    tbl[5]  = '{0,0,1,0, 8'hC0, 8'h00, 1, 8'h82, 4'd2, 0,0,0};
    tbl[6]  = '{0,0,1,0, 8'h82, 8'h00, 1, 8'h42, 4'd1, 0,0,0};
    tbl[7]  = '{0,0,1,0, 8'h42, 8'h00, 1, 8'h06, 4'd0, 0,0,0};
    tbl[8]  = '{1,0,0,0, 8'hFF, 8'h10, 1, 8'h10, 4'd1, 0,0,0};
    tbl[9]  = '{0,0,1,0, 8'h10, 8'h00, 1, 8'h00, 4'd0, 0,0,0};
    tbl[10] = '{0,1,0,0, 8'h00, 8'h33, 1, 8'h33, 4'd0, 0,0,0};
    tbl[11] = '{1,0,0,0, 8'h20, 8'h50, 1, 8'h50, 4'd1, 0,0,0};
    tbl[12] = '{1,0,1,0, 8'h30, 8'h70, 1, 8'h70, 4'd2, 0,0,1};
    tbl[13] = '{0,0,0,1, 8'h70, 8'h00, 0, 8'h00, 4'd2, 0,0,0};
    tbl[14] = '{0,0,1,0, 8'h71, 8'h00, 1, 8'h31, 4'd1, 0,0,0};
    tbl[15] = '{0,0,1,0, 8'h31, 8'h00, 1, 8'h21, 4'd0, 0,0,0};
    tbl[16] = '{0,0,1,0, 8'h21, 8'h00, 0, 8'h00, 4'd0, 0,1,0};
    tbl[17] = '{0,0,0,1, 8'h22, 8'h00, 0, 8'h00, 4'd0, 0,0,0};
    tbl[18] = '{0,1,1,0, 8'h23, 8'h44, 1, 8'h44, 4'd0, 0,0,1};
    tbl[19] = '{0,0,0,1, 8'h44, 8'h00, 0, 8'h00, 4'd0, 0,0,0};

    for (int i = 0; i < 20; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      cycle(tbl[i].c, tbl[i].j, tbl[i].r, tbl[i].clr, tbl[i].pc, tbl[i].lit, 0, t, ld, k8);
      chk({t, ".load"},  32'(ld), 32'(tbl[i].ld));
      chk({t, ".k8"},    32'(k8), 32'(tbl[i].k8));
      chk({t, ".depth"}, 32'(bus.depth), 32'(tbl[i].dep));
      chk({t, ".flags"}, {29'd0, bus.overflow, bus.underflow, bus.conflict},
                         {29'd0, tbl[i].ovf, tbl[i].udf, tbl[i].cnf});
    end

    // Fill to capacity, overflow (with a simultaneous clr_err), drain, underflow.
    for (int i = 0; i < DEPTH; i++)
      cycle(1, 0, 0, 0, 8'(i * 16), 8'(i + 8'h90), 0, "fill", ld, k8);
    chk("fill.full",  32'(bus.full),  1);
    chk("fill.depth", 32'(bus.depth), DEPTH);
    cycle(1, 0, 0, 0, 8'hEE, 8'h20, 0, "ovf", ld, k8);
    chk("ovf.load",  32'(ld), 1);
    chk("ovf.k8",    32'(k8), 32'h20);
    chk("ovf.depth", 32'(bus.depth), DEPTH);
    chk("ovf.flag",  32'(bus.overflow), 1);
    cycle(1, 0, 0, 1, 8'hEE, 8'h21, 0, "ovf_clr", ld, k8);
    chk("ovf_clr.flag", 32'(bus.overflow), 1);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      cycle(0, 0, 1, 0, 8'h00, 8'h00, 0, "drain", ld, k8);
      chk($sformatf("drain%0d.k8", i), 32'(k8), 32'(8'(i * 16 + 1)));
    end
    cycle(0, 0, 1, 0, 8'h00, 8'h00, 0, "udf", ld, k8);
    chk("udf.load", 32'(ld), 0);
    chk("udf.flag", 32'(bus.underflow), 1);
    cycle(0, 0, 0, 1, 8'h00, 8'h00, 1, "clr_all", ld, k8);
    check_model_state("clr_all");

    // Async reset in the middle of a cycle, with a flag set beforehand.
    cycle(1, 0, 0, 0, 8'h01, 8'h10, 1, "ar0", ld, k8);
    cycle(1, 0, 0, 0, 8'h11, 8'h20, 1, "ar1", ld, k8);
    cycle(1, 1, 0, 0, 8'h21, 8'h30, 1, "ar2", ld, k8);
    chk("ar.depth3",   32'(bus.depth), 3);
    chk("ar.conflict", 32'(bus.conflict), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar.depth", 32'(bus.depth), 0);
    chk("ar.empty", 32'(bus.empty), 1);
    chk("ar.flags", {29'd0, bus.overflow, bus.underflow, bus.conflict}, 0);
    #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    cycle(0, 0, 1, 0, 8'h50, 8'h00, 1, "ar_ret", ld, k8);
    chk("ar_ret.underflow", 32'(bus.underflow), 1);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      int  x;
      logic c, j, r, clr;
      x   = $urandom_range(0, 99);
      c   = (x < 30);
      j   = (x >= 30 && x < 38);
      r   = (x >= 38 && x < 78);
      if ($urandom_range(0, 19) == 0) r = 1'b1;
      if ($urandom_range(0, 29) == 0) j = 1'b1;
      clr = ($urandom_range(0, 15) == 0);
      cycle(c, j, r, clr, 8'($urandom), 8'($urandom), 1, "rnd", ld, k8);
      check_model_state("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ret_stack.md
Name: ret_stack

Overview:
- Control-flow partner of the program counter: drives the PC's `k8` and `load` inputs for JMP/CALL/RET.
- Keeps a hardware return-address stack.
- CALL pushes the return address (pc+1) and redirects to the instruction literal; RET pops and redirects to the stacked address; JMP redirects without touching the stack.
- Sits between the CU (which decodes `jmp`/`call`/`ret` and supplies the literal) and the PC register.

Parameters:
- DEPTH, 8, number of return-address entries (power of two, >=2).
- AW, 8, address width; matches the PC width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc  input  AW  current PC value (address of the executing instruction).
- lit  input  AW  instruction literal (jump/call target) from CU.
- jmp  input  1  CU strobe: unconditional jump to `lit`.
- call  input  1  CU strobe: push pc+1, jump to `lit`.
- ret  input  1  CU strobe: pop, jump to popped address.
- clr_err  input  1  clears sticky error flags.
- k8  output  AW  load value to PC (combinational).
- load  output  1  PC load enable (combinational).
- depth  output  $clog2(DEPTH+1)  current number of stacked entries.
- full  output  1  depth == DEPTH.
- empty  output  1  depth == 0.
- overflow  output  1  sticky: CALL attempted while full.
- underflow  output  1  sticky: RET attempted while empty.
- conflict  output  1  sticky: more than one of jmp/call/ret asserted in the same cycle.

Behaviour:
- Reset (rst_n low, asynchronous): depth=0, overflow=underflow=conflict=0, stack pointer=0. Entry storage is not cleared; it is unreachable while empty.
- k8/load are combinational, so the PC loads on the same rising edge the strobe is sampled. Zero-cycle redirect latency.
- Priority when strobes overlap: call > jmp > ret. Lower-priority strobes are ignored entirely (no pop, no push) and conflict is set at that edge.
- call: load=1, k8=lit. At the edge, push (pc+1) mod 2^AW and increment depth. pc=255 pushes 0 (AW=8 wrap).
- call while full: load=1, k8=lit (jump still taken); push discarded; depth unchanged; overflow set.
- jmp: load=1, k8=lit; stack untouched.
- ret, not empty: load=1, k8=top entry; depth decrements at the edge.
- ret while empty: load=0, k8=0 (PC increments normally); depth stays 0; underflow set.
- No strobe: load=0, k8=0.
- Storage and depth update only on rising clk with rst_n high. Top entry = storage[depth-1]. Push writes storage[depth].
- Sticky flags:
  - Set at the edge where the condition is sampled; remain set until clr_err or reset.
  - clr_err at the same edge as a new error: the set wins.
- Reset mid-sequence (e.g. between CALL and RET): stack empties immediately. A following RET is an underflow.
- full/empty/depth are registered-state derived. They reflect the state after the last edge, not pending strobes.

Test Plan:
- Reset, pc=8'h10, lit=8'h40, call=1 for 1 cycle -> same cycle load=1, k8=8'h40; after edge depth=1, empty=0. Next cycle ret=1 -> load=1, k8=8'h11; after edge depth=0, empty=1.
- Nested: three calls from pc=8'h05,8'h41,8'h81 with lit=8'h40,8'h80,8'hC0 -> depth=3. Three rets -> k8 sequence 8'h82, 8'h42, 8'h06. No flags set.
- Fill: 8 calls -> full=1, depth=8. 9th call with lit=8'h20 -> load=1, k8=8'h20, depth stays 8, overflow=1. 8 rets return the first eight addresses in LIFO order. 9th ret -> load=0, underflow=1.
- Wrap: pc=8'hFF, call -> pushed 8'h00; ret -> k8=8'h00. jmp with lit=8'h33 -> load=1, k8=8'h33, depth unchanged.
- Conflict: depth=1, call and ret both asserted with lit=8'h70 -> k8=8'h70, depth=2, conflict=1. clr_err for one cycle -> all flags 0.
- Async reset: depth=3, drop rst_n mid-cycle (no clock edge) -> depth=0, empty=1, flags 0 immediately. ret after release -> load=0, underflow=1.
